data_mem_stage: RTL and testbench

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/data_mem_stage.sv | 172 +++++++++++++++++
 tb/tb_data_mem_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// Data memory stage: byte-addressable word array with sub-word loads/stores,
// misalignment detection and a configurable-latency stall handshake.
module data_mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadM,
    input  logic        memWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] addrM,
    input  logic [31:0] writeDataM,
    output logic [31:0] RDM,
    output logic        stallM,
    output logic        misalignM
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        stall_raw;
    logic        do_access;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic        req_active;
    logic        is_half, is_word;
    logic        f3_ok;
    logic        req_ok;
    logic        mem_we;
    logic [3:0]  be;
    logic [31:0] st_data;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic        unused_ok;

    assign idx        = addrM[IDX_W+1:2];
    assign unused_ok  = ^addrM[31:IDX_W+2];
    assign req_active = memReadM | memWriteM;
    assign is_half    = (funct3M[1:0] == 2'b01);
    assign is_word    = (funct3M == 3'b010);
    assign misalignM  = req_active & ((is_half & addrM[0]) | (is_word & (addrM[1:0] != 2'b00)));
    assign rd_word    = mem[idx];

    // Decode legality: stores accept only sb/sh/sw, loads also accept lbu/lhu.
    always_comb begin
        f3_ok = 1'b0;
        if (memWriteM) begin
            f3_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
        end else begin
            f3_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
                    (funct3M == 3'b100) || (funct3M == 3'b101);
        end
    end

    assign req_ok = req_active & ~misalignM & f3_ok;

    // Store lane enables and lane-replicated store data.
    always_comb begin
        be      = 4'b1111;
        st_data = writeDataM;
        case (funct3M[1:0])
            2'b00: begin
                be      = 4'b0001 << addrM[1:0];
                st_data = {4{writeDataM[7:0]}};
            end
            2'b01: begin
                be      = addrM[1] ? 4'b1100 : 4'b0011;
                st_data = {2{writeDataM[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                st_data = writeDataM;
            end
        endcase
    end

    // Merge new lanes over the current word so untouched bytes are preserved.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word[8*gi +: 8] = be[gi] ? st_data[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    // Load alignment and sign/zero extension of the selected byte or half.
    always_comb begin
        shifted  = rd_word >> {addrM[1:0], 3'b000};
        load_val = 32'h0;
        case (funct3M)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            default: load_val = 32'h0;
        endcase
    end

    // Next-state logic. The IDLE cycle that accepts the request already
    // stalls, so WAIT only covers the remaining WAIT_CYCLES-1 stall cycles;
    // that keeps the total stall per access equal to WAIT_CYCLES.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                    end else begin
                        stall_raw = 1'b1;
                        cnt_d     = 8'(WAIT_CYCLES - 1);
                        state_d   = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_raw = 1'b1;
                if (!req_active) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                do_access = req_ok;
                state_d   = S_IDLE;
                cnt_d     = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Reset overrides the handshake immediately, without waiting for a clock.
    assign stallM = stall_raw & ~rst;
    assign mem_we = do_access & memWriteM & ~rst;
    assign RDM    = (do_access & memReadM & ~memWriteM & ~rst) ? load_val : 32'h0;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wr_word;
        end
    end
endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage: one instance with single-cycle access
// and one with two wait cycles, driven by directed vectors.
module tb_data_mem_stage;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rd0, wr0, stall0, mis0;
    logic [2:0]  f3_0;
    logic [31:0] a0, wd0, rdm0;
    logic        rst1, rd1, wr1, stall1, mis1;
    logic [2:0]  f3_1;
    logic [31:0] a1, wd1, rdm1;

    data_mem_stage #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .memReadM(rd0), .memWriteM(wr0), .funct3M(f3_0),
        .addrM(a0), .writeDataM(wd0), .RDM(rdm0), .stallM(stall0), .misalignM(mis0)
    );

    data_mem_stage #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst1), .memReadM(rd1), .memWriteM(wr1), .funct3M(f3_1),
        .addrM(a1), .writeDataM(wd1), .RDM(rdm1), .stallM(stall1), .misalignM(mis1)
    );

    int total = 0;
    int bad   = 0;

    // Expected {misalignM, RDM} per completed access.
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            rd0 = rd; wr0 = wr; f3_0 = f3; a0 = a; wd0 = wd;
        end else begin
            rd1 = rd; wr1 = wr; f3_1 = f3; a1 = a; wd1 = wd;
        end
    endtask

    // Hold a request stable until the DUT stops stalling, counting stall cycles.
    task automatic access(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rdm, input logic exp_mis, input int exp_stall);
        int  stalls;
        bit  done;
        if (d == 0) q0.push_back({exp_mis, exp_rdm});
        else        q1.push_back({exp_mis, exp_rdm});
        @(posedge clk); #1;
        set_in(d, rd, wr, f3, a, wd);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((d == 0 ? stall0 : stall1) == 1'b1) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout dut%0d addr 0x%08h: stall never released", d, a);
        end
        chk($sformatf("stall_cycles dut%0d @0x%08h", d, a), stalls, exp_stall);
        @(posedge clk); #1;
        set_in(d, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Monitor for the single-cycle instance.
    always @(negedge clk) begin
        if (!rst0 && (rd0 || wr0) && !stall0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dut0 unexpected completion rdm=0x%08h", rdm0);
            end else begin
                logic [32:0] e;
                e = q0.pop_front();
                chk("dut0 rdm", rdm0, e[31:0]);
                chk("dut0 misalign", {31'h0, mis0}, {31'h0, e[32]});
                $display("tx dut0 rd=%0b wr=%0b f3=%0d addr=0x%08h rdm=0x%08h mis=%0b",
                         rd0, wr0, f3_0, a0, rdm0, mis0);
            end
        end
    end

    // Monitor for the wait-state instance.
    always @(negedge clk) begin
        if (!rst1 && (rd1 || wr1) && !stall1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1 unexpected completion rdm=0x%08h", rdm1);
            end else begin
                logic [32:0] e;
                e = q1.pop_front();
                chk("dut1 rdm", rdm1, e[31:0]);
                chk("dut1 misalign", {31'h0, mis1}, {31'h0, e[32]});
                $display("tx dut1 rd=%0b wr=%0b f3=%0d addr=0x%08h rdm=0x%08h mis=%0b",
                         rd1, wr1, f3_1, a1, rdm1, mis1);
            end
        end
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        set_in(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_in(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("reset stall0", {31'h0, stall0}, 32'h0);
        chk("reset rdm0", rdm0, 32'h0);
        chk("reset stall1", {31'h0, stall1}, 32'h0);
        chk("reset rdm1", rdm1, 32'h0);

        // Single-cycle instance.
        access(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0);
        access(0, 1, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 0);
        access(0, 1, 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 0);
        access(0, 1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 0);
        access(0, 1, 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0, 0);
        access(0, 0, 1, 3'b000, 32'h11, 32'h12345677, 32'h0,        0, 0);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0, 0);
        access(0, 1, 0, 3'b010, 32'h12, 32'h0,        32'h0,        1, 0);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0, 0);
        access(0, 0, 1, 3'b001, 32'h13, 32'h00001111, 32'h0,        1, 0);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0, 0);
        access(0, 1, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0,        0, 0);
        access(0, 1, 0, 3'b010, 32'h20, 32'h0,        32'hCAFEF00D, 0, 0);
        access(0, 1, 0, 3'b010, 32'h420, 32'h0,       32'hCAFEF00D, 0, 0);
        access(0, 1, 0, 3'b011, 32'h20, 32'h0,        32'h0,        0, 0);
        access(0, 0, 1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0,        0, 0);
        access(0, 0, 1, 3'b100, 32'h20, 32'h0,        32'h0,        0, 0);
        access(0, 1, 0, 3'b010, 32'h20, 32'h0,        32'hABCDF00D, 0, 0);
        access(0, 1, 0, 3'b000, 32'h20, 32'h0,        32'h0000000D, 0, 0);
        access(0, 1, 0, 3'b001, 32'h22, 32'h0,        32'hFFFFABCD, 0, 0);

        // Two-wait-cycle instance.
        access(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2);
        access(1, 0, 1, 3'b000, 32'h11, 32'h12345677, 32'h0,        0, 2);
        access(1, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0, 2);
        access(1, 1, 0, 3'b010, 32'h12, 32'h0,        32'h0,        1, 0);
        access(1, 1, 0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 0, 2);

        // Store aborted by reset during the first WAIT cycle.
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        chk("rst-abort stall in IDLE", {31'h0, stall1}, 32'h1);
        @(posedge clk); #1;
        chk("rst-abort stall in WAIT", {31'h0, stall1}, 32'h1);
        rst1 = 1'b1;
        #1;
        chk("rst-abort stall drop", {31'h0, stall1}, 32'h0);
        set_in(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst1 = 1'b0;
        access(1, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0, 2);

        // Store abandoned by dropping the request in WAIT.
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("drop stall in WAIT", {31'h0, stall1}, 32'h1);
        @(posedge clk); #1;
        chk("drop back to idle stall", {31'h0, stall1}, 32'h0);
        chk("drop idle rdm", rdm1, 32'h0);
        access(1, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0, 2);

        repeat (2) @(posedge clk);
        chk("dut0 scoreboard drained", q0.size(), 32'h0);
        chk("dut1 scoreboard drained", q1.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
